// File: rtl/golay_codec_sched_if.sv
// golay_codec_sched_if: request/response handshakes, shared-core strobes and statistics of the Golay scheduler
interface golay_codec_sched_if #(parameter int CNT_W = 16);
  logic enc_valid, enc_ready, enc_rsp_valid;
  logic [11:0] enc_payload, enc_codeword;
  logic dec_valid, dec_ready, dec_rsp_valid, dec_failed, dec_timeout;
  logic [23:0] dec_codepay;
  logic [11:0] dec_payload;
  logic core_stb, core_stb_dec, core_decoded, core_failed;
  logic [11:0] core_payload, core_codeword, core_payload_rec;
  logic [23:0] core_codepay;
  logic busy;
  logic [CNT_W-1:0] enc_cnt, dec_ok_cnt, dec_fail_cnt;
  modport slave (
    input enc_valid, enc_payload, dec_valid, dec_codepay,
    input core_codeword, core_decoded, core_failed, core_payload_rec,
    output enc_ready, enc_rsp_valid, enc_codeword,
    output dec_ready, dec_rsp_valid, dec_payload, dec_failed, dec_timeout,
    output core_stb, core_payload, core_stb_dec, core_codepay,
    output busy, enc_cnt, dec_ok_cnt, dec_fail_cnt
  );
  modport master (
    output enc_valid, enc_payload, dec_valid, dec_codepay,
    output core_codeword, core_decoded, core_failed, core_payload_rec,
    input enc_ready, enc_rsp_valid, enc_codeword,
    input dec_ready, dec_rsp_valid, dec_payload, dec_failed, dec_timeout,
    input core_stb, core_payload, core_stb_dec, core_codepay,
    input busy, enc_cnt, dec_ok_cnt, dec_fail_cnt
  );
endinterface

// File: rtl/golay_codec_sched.sv
// golay_codec_sched: round-robin scheduler sharing one Golay encoder/decoder core between encode and decode requests
module golay_codec_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  golay_codec_sched_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ENC_ISSUE, ENC_CAP, DEC_ISSUE, DEC_WAIT} state_t;
  state_t state, state_nx;
  logic last_dec, enc_acc, dec_acc, done, timed_out;
  logic [TW-1:0] wait_cnt;
  logic [11:0] payload_q, enc_codeword, dec_payload;
  logic [23:0] codepay_q;
  logic enc_rsp_valid, dec_rsp_valid, dec_failed, dec_timeout;
  logic [CNT_W-1:0] enc_cnt, dec_ok_cnt, dec_fail_cnt;
  // last_dec set means the decoder was granted last, so the encoder wins the next tie
  assign enc_acc = state == IDLE && bus.enc_valid && (!bus.dec_valid || last_dec);
  assign dec_acc = state == IDLE && bus.dec_valid && (!bus.enc_valid || !last_dec);
  assign done = state == DEC_WAIT && (bus.core_decoded || bus.core_failed);
  assign timed_out = state == DEC_WAIT && !done && wait_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = enc_acc ? ENC_ISSUE : dec_acc ? DEC_ISSUE : IDLE;
      ENC_ISSUE: state_nx = ENC_CAP;
      ENC_CAP:   state_nx = IDLE;
      DEC_ISSUE: state_nx = DEC_WAIT;
      DEC_WAIT:  state_nx = (done || timed_out) ? IDLE : DEC_WAIT;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_dec <= 1'b1;
      payload_q <= '0;
      codepay_q <= '0;
      wait_cnt <= '0;
      enc_rsp_valid <= 1'b0;
      enc_codeword <= '0;
      dec_rsp_valid <= 1'b0;
      dec_payload <= '0;
      dec_failed <= 1'b0;
      dec_timeout <= 1'b0;
      enc_cnt <= '0;
      dec_ok_cnt <= '0;
      dec_fail_cnt <= '0;
    end else begin
      enc_rsp_valid <= 1'b0;
      dec_rsp_valid <= 1'b0;
      wait_cnt <= state == DEC_WAIT ? wait_cnt + TW'(1) : '0;
      if (enc_acc) begin
        payload_q <= bus.enc_payload;
        last_dec <= 1'b0;
      end
      if (dec_acc) begin
        codepay_q <= bus.dec_codepay;
        last_dec <= 1'b1;
      end
      if (state == ENC_CAP) begin
        enc_rsp_valid <= 1'b1;
        enc_codeword <= bus.core_codeword;
        enc_cnt <= enc_cnt + {{(CNT_W-1){1'b0}}, ~&enc_cnt};
      end
      if (done || timed_out) begin
        dec_rsp_valid <= 1'b1;
        dec_payload <= timed_out ? 12'h000 : bus.core_payload_rec;
        dec_failed <= timed_out || bus.core_failed;
        dec_timeout <= timed_out;
        if (timed_out || bus.core_failed) dec_fail_cnt <= dec_fail_cnt + {{(CNT_W-1){1'b0}}, ~&dec_fail_cnt};
        else dec_ok_cnt <= dec_ok_cnt + {{(CNT_W-1){1'b0}}, ~&dec_ok_cnt};
      end
    end
  end
  assign bus.enc_ready = enc_acc;
  assign bus.dec_ready = dec_acc;
  assign bus.busy = state != IDLE;
  assign bus.core_stb = state == ENC_ISSUE;
  assign bus.core_stb_dec = state == DEC_ISSUE;
  assign bus.core_payload = payload_q;
  assign bus.core_codepay = codepay_q;
  assign bus.enc_rsp_valid = enc_rsp_valid;
  assign bus.enc_codeword = enc_codeword;
  assign bus.dec_rsp_valid = dec_rsp_valid;
  assign bus.dec_payload = dec_payload;
  assign bus.dec_failed = dec_failed;
  assign bus.dec_timeout = dec_timeout;
  assign bus.enc_cnt = enc_cnt;
  assign bus.dec_ok_cnt = dec_ok_cnt;
  assign bus.dec_fail_cnt = dec_fail_cnt;
endmodule

// File: tb/tb_golay_codec_sched.sv
// tb_golay_codec_sched: directed tests of arbitration, encode/decode timing, timeout, reset and counter saturation
module tb_golay_codec_sched;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_enc = 0, exp_ok = 0, exp_fail = 0;
  golay_codec_sched_if #(.CNT_W(CNT_W)) bus();
  golay_codec_sched #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    #1;
    checks++; if ({bus.busy, bus.enc_ready, bus.dec_ready, bus.core_stb, bus.core_stb_dec} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b, required 00000", {bus.busy, bus.enc_ready, bus.dec_ready, bus.core_stb, bus.core_stb_dec}); end
    checks++; if ({bus.enc_rsp_valid, bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout} !== 4'b0) begin errors++; $display("FAIL reset_rsp: got %b, required 0000", {bus.enc_rsp_valid, bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout}); end
    checks++; if ({bus.enc_cnt, bus.dec_ok_cnt, bus.dec_fail_cnt} !== '0) begin errors++; $display("FAIL reset_cnt: got %h/%h/%h, required 0/0/0", bus.enc_cnt, bus.dec_ok_cnt, bus.dec_fail_cnt); end
    checks++; if ({bus.core_payload, bus.core_codepay, bus.enc_codeword, bus.dec_payload} !== '0) begin errors++; $display("FAIL reset_data: got %h %h %h %h, required zeros", bus.core_payload, bus.core_codepay, bus.enc_codeword, bus.dec_payload); end
    reset = 1'b0;
    exp_enc = 0; exp_ok = 0; exp_fail = 0;
  endtask
  task automatic test_tie;
    int n = 0;
    logic g [4];
    bus.core_decoded = 1'b1;
    bus.enc_valid = 1'b1; bus.enc_payload = 12'h111;
    bus.dec_valid = 1'b1; bus.dec_codepay = 24'h222222;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      checks++; if (bus.enc_ready && bus.dec_ready) begin errors++; $display("FAIL tie_both_ready: got 11, required at most one"); end
      checks++; if (bus.busy !== !(bus.enc_ready || bus.dec_ready)) begin errors++; $display("FAIL tie_busy: got %b, required %b", bus.busy, !(bus.enc_ready || bus.dec_ready)); end
      if (bus.enc_ready || bus.dec_ready) begin g[n] = bus.dec_ready; n++; end
      tick();
    end
    bus.enc_valid = 1'b0; bus.dec_valid = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL tie_grants: got %0d grants, required 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (g[i] !== 1'(i & 1)) begin errors++; $display("FAIL tie_order%0d: got %0d, required %0d", i, g[i], i & 1); end
    end
    repeat (6) tick();
    bus.core_decoded = 1'b0;
    exp_enc += 2; exp_ok += 2;
    checks++; if (bus.enc_cnt !== CNT_W'(exp_enc) || bus.dec_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL tie_cnt: got %0d/%0d, required %0d/%0d", bus.enc_cnt, bus.dec_ok_cnt, exp_enc, exp_ok); end
  endtask
  task automatic test_encode;
    bus.enc_valid = 1'b1; bus.enc_payload = 12'hABC;
    #1;
    checks++; if ({bus.enc_ready, bus.dec_ready} !== 2'b10) begin errors++; $display("FAIL enc_ready: got %b, required 10", {bus.enc_ready, bus.dec_ready}); end
    tick();
    bus.enc_valid = 1'b0; bus.enc_payload = 12'h000; bus.core_codeword = 12'hFFF;
    #1;
    checks++; if ({bus.core_stb, bus.core_stb_dec, bus.busy} !== 3'b101 || bus.core_payload !== 12'hABC) begin errors++; $display("FAIL enc_issue: got stb %b payload %h, required 101 abc", {bus.core_stb, bus.core_stb_dec, bus.busy}, bus.core_payload); end
    tick();
    bus.core_codeword = 12'h123;
    #1;
    checks++; if (bus.core_stb !== 1'b0 || bus.enc_rsp_valid !== 1'b0 || bus.core_payload !== 12'hABC) begin errors++; $display("FAIL enc_cap: got stb %b rsp %b payload %h, required 0 0 abc", bus.core_stb, bus.enc_rsp_valid, bus.core_payload); end
    tick();
    bus.core_codeword = 12'hEEE;
    #1;
    exp_enc++;
    checks++; if (bus.enc_rsp_valid !== 1'b1 || bus.enc_codeword !== 12'h123 || bus.busy !== 1'b0) begin errors++; $display("FAIL enc_rsp: got v %b cw %h busy %b, required 1 123 0", bus.enc_rsp_valid, bus.enc_codeword, bus.busy); end
    checks++; if (bus.enc_cnt !== CNT_W'(exp_enc)) begin errors++; $display("FAIL enc_cnt: got %0d, required %0d", bus.enc_cnt, exp_enc); end
    tick();
    #1;
    checks++; if (bus.enc_rsp_valid !== 1'b0 || bus.enc_codeword !== 12'h123) begin errors++; $display("FAIL enc_hold: got v %b cw %h, required 0 123", bus.enc_rsp_valid, bus.enc_codeword); end
  endtask
  task automatic test_decode(input logic both, input logic [11:0] rec);
    bus.dec_valid = 1'b1; bus.dec_codepay = 24'h000ABC;
    #1;
    checks++; if ({bus.enc_ready, bus.dec_ready} !== 2'b01) begin errors++; $display("FAIL dec_ready: got %b, required 01", {bus.enc_ready, bus.dec_ready}); end
    tick();
    bus.dec_valid = 1'b0; bus.dec_codepay = 24'hFFFFFF;
    #1;
    checks++; if ({bus.core_stb_dec, bus.core_stb} !== 2'b10 || bus.core_codepay !== 24'h000ABC) begin errors++; $display("FAIL dec_issue: got stb %b cp %h, required 10 000abc", {bus.core_stb_dec, bus.core_stb}, bus.core_codepay); end
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      checks++; if (bus.dec_rsp_valid !== 1'b0 || bus.core_stb_dec !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL dec_wait%0d: got rsp %b stb %b busy %b, required 0 0 1", i, bus.dec_rsp_valid, bus.core_stb_dec, bus.busy); end
    end
    bus.core_decoded = 1'b1; bus.core_failed = both; bus.core_payload_rec = rec;
    tick();
    bus.core_decoded = 1'b0; bus.core_failed = 1'b0; bus.core_payload_rec = 12'h000;
    #1;
    if (both) exp_fail++; else exp_ok++;
    checks++; if ({bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout, bus.busy} !== {1'b1, both, 2'b00} || bus.dec_payload !== rec) begin errors++; $display("FAIL dec_rsp: got vftb %b payload %h, required %b %h", {bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout, bus.busy}, bus.dec_payload, {1'b1, both, 2'b00}, rec); end
    checks++; if (bus.dec_ok_cnt !== CNT_W'(exp_ok) || bus.dec_fail_cnt !== CNT_W'(exp_fail)) begin errors++; $display("FAIL dec_cnt: got %0d/%0d, required %0d/%0d", bus.dec_ok_cnt, bus.dec_fail_cnt, exp_ok, exp_fail); end
    tick();
  endtask
  task automatic test_timeout;
    bus.dec_valid = 1'b1; bus.dec_codepay = 24'h123456;
    tick();
    bus.dec_valid = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      #1;
      checks++; if (bus.dec_rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early%0d: got rsp 1, required 0", t); end
      tick();
    end
    #1;
    exp_fail++;
    checks++; if ({bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout, bus.busy} !== 4'b1110 || bus.dec_payload !== 12'h000) begin errors++; $display("FAIL to_rsp: got vftb %b payload %h, required 1110 000", {bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout, bus.busy}, bus.dec_payload); end
    checks++; if (bus.dec_fail_cnt !== CNT_W'(exp_fail)) begin errors++; $display("FAIL to_cnt: got %0d, required %0d", bus.dec_fail_cnt, exp_fail); end
    tick();
    tick();
    bus.core_decoded = 1'b1; bus.core_payload_rec = 12'h777;
    tick();
    bus.core_decoded = 1'b0; bus.core_payload_rec = 12'h000;
    #1;
    checks++; if (bus.dec_rsp_valid !== 1'b0 || bus.dec_ok_cnt !== CNT_W'(exp_ok) || bus.dec_timeout !== 1'b1) begin errors++; $display("FAIL to_late: got rsp %b ok %0d to %b, required 0 %0d 1", bus.dec_rsp_valid, bus.dec_ok_cnt, bus.dec_timeout, exp_ok); end
    bus.dec_valid = 1'b1; bus.dec_codepay = 24'h654321;
    tick();
    bus.dec_valid = 1'b0;
    repeat (8) tick();
    bus.core_decoded = 1'b1; bus.core_payload_rec = 12'h9C9;
    tick();
    bus.core_decoded = 1'b0; bus.core_payload_rec = 12'h000;
    #1;
    exp_ok++;
    checks++; if ({bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout} !== 3'b100 || bus.dec_payload !== 12'h9C9) begin errors++; $display("FAIL to_last_cycle: got vft %b payload %h, required 100 9c9", {bus.dec_rsp_valid, bus.dec_failed, bus.dec_timeout}, bus.dec_payload); end
    checks++; if (bus.dec_ok_cnt !== CNT_W'(exp_ok) || bus.dec_fail_cnt !== CNT_W'(exp_fail)) begin errors++; $display("FAIL to_last_cnt: got %0d/%0d, required %0d/%0d", bus.dec_ok_cnt, bus.dec_fail_cnt, exp_ok, exp_fail); end
    tick();
  endtask
  task automatic test_reset_mid;
    bus.dec_valid = 1'b1; bus.dec_codepay = 24'hABCDEF;
    tick();
    bus.dec_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1; bus.core_decoded = 1'b1; bus.core_payload_rec = 12'h555;
    tick();
    reset = 1'b0; bus.core_decoded = 1'b0; bus.core_payload_rec = 12'h000;
    #1;
    checks++; if ({bus.dec_rsp_valid, bus.busy, bus.dec_failed} !== 3'b000 || bus.dec_payload !== 12'h000) begin errors++; $display("FAIL rst_mid_rsp: got v/busy/f %b payload %h, required 000 000", {bus.dec_rsp_valid, bus.busy, bus.dec_failed}, bus.dec_payload); end
    checks++; if ({bus.enc_cnt, bus.dec_ok_cnt, bus.dec_fail_cnt} !== '0 || bus.core_codepay !== 24'h0 || bus.enc_codeword !== 12'h0) begin errors++; $display("FAIL rst_mid_regs: got %0d/%0d/%0d cp %h cw %h, required zeros", bus.enc_cnt, bus.dec_ok_cnt, bus.dec_fail_cnt, bus.core_codepay, bus.enc_codeword); end
    bus.enc_valid = 1'b1; bus.dec_valid = 1'b1;
    #1;
    checks++; if ({bus.enc_ready, bus.dec_ready} !== 2'b10) begin errors++; $display("FAIL rst_mid_tie: got %b, required 10", {bus.enc_ready, bus.dec_ready}); end
    bus.enc_valid = 1'b0; bus.dec_valid = 1'b0;
    tick();
  endtask
  task automatic test_saturation;
    for (int k = 1; k <= 17; k++) begin
      bus.enc_valid = 1'b1; bus.enc_payload = 12'(k);
      tick();
      bus.enc_valid = 1'b0;
      tick();
      tick();
      if (k == 15) begin
        #1;
        checks++; if (bus.enc_cnt !== 4'hF) begin errors++; $display("FAIL sat_15: got %0d, required 15", bus.enc_cnt); end
      end
      tick();
    end
    #1;
    checks++; if (bus.enc_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d, required 15", bus.enc_cnt); end
  endtask
  initial begin
    bus.enc_valid = 1'b0; bus.enc_payload = '0; bus.dec_valid = 1'b0; bus.dec_codepay = '0;
    bus.core_codeword = '0; bus.core_decoded = 1'b0; bus.core_failed = 1'b0; bus.core_payload_rec = '0;
    test_reset();
    test_tie();
    test_encode();
    test_decode(1'b0, 12'h5A5);
    test_decode(1'b1, 12'h3C3);
    test_timeout();
    test_reset_mid();
    test_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
